// File: rtl/servo_pwm_driver_if.sv
// servo_pwm_driver_if
//   Groups the servo driver's control and status signals into one bundle.
//   Ports (signals):
//     enable      high = drive the servo, low = idle with the output quiet
//     angle_in    requested angle in degrees (8-bit unsigned)
//     pwm_out     registered servo control pulse
//     frame_tick  one-cycle pulse at the start of every active frame
//     angle_cur   angle applied in the current frame
//     busy        applied angle has not yet reached the latched request
//   Modports:
//     master  requester side (drives enable/angle_in, observes status)
//     slave   driver side (servo_pwm_driver)
interface servo_pwm_driver_if;
    logic       enable;
    logic [7:0] angle_in;
    logic       pwm_out;
    logic       frame_tick;
    logic [7:0] angle_cur;
    logic       busy;

    modport master (
        output enable, angle_in,
        input  pwm_out, frame_tick, angle_cur, busy
    );

    modport slave (
        input  enable, angle_in,
        output pwm_out, frame_tick, angle_cur, busy
    );
endinterface

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   Generates a hobby-servo PWM frame: one pulse per FRAME_TICKS cycles whose
//   width is MIN_PULSE + angle * TICKS_PER_DEG. The requested angle is sampled
//   and clamped to 0..180 at each frame start and held for the whole frame.
//   Optional build macro:
//     SERVO_SLEW_EN  when defined, the applied angle moves toward the request by
//                    at most SLEW_STEP degrees per frame and busy reports that
//                    the move is still in progress. When undefined the request
//                    is applied directly and busy stays low.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    servo_pwm_driver_if.slave (enable, angle_in in; pwm_out,
//            frame_tick, angle_cur, busy out)
module servo_pwm_driver #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int FRAME_TICKS   = 1_000_000,
    parameter int MIN_PULSE     = 25_000,
    parameter int TICKS_PER_DEG = 556,
    parameter int SLEW_STEP     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    servo_pwm_driver_if.slave   bus
);
    localparam int MAX_PULSE = MIN_PULSE + 180 * TICKS_PER_DEG;
    // At least 17 bits so the default 125_080-cycle pulse never truncates.
    localparam int PW_W  = ($clog2(MAX_PULSE + 1) > 17) ? $clog2(MAX_PULSE + 1) : 17;
    localparam int CNT_W = $clog2(FRAME_TICKS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_TICKS - 1);
    localparam logic [7:0]       ANGLE_MAX  = 8'd180;
    localparam logic [7:0]       ANGLE_IDLE = 8'd90;
    localparam logic [PW_W-1:0]  PW_IDLE    = PW_W'(MIN_PULSE + 90 * TICKS_PER_DEG);

    // The pulse must start in the frame_tick cycle and fit inside the frame.
    if (CLK_FREQ <= 0 || FRAME_TICKS < 2 || MIN_PULSE < 1 || SLEW_STEP < 1 ||
        MAX_PULSE > FRAME_TICKS) begin : g_bad_cfg
        $error("servo_pwm_driver: invalid parameter set");
    end

    logic [CNT_W-1:0] cnt;
    logic [PW_W-1:0]  pulse_w;
    logic [PW_W-1:0]  pulse_w_new;
    logic [7:0]       angle_cur_q;
    logic [7:0]       target;
    logic [7:0]       angle_new;
    logic             busy_new;
    logic             frame_start;
    logic             pwm_q;
    logic             tick_q;
    logic             busy_q;

    assign frame_start = bus.enable && (cnt == '0);
    assign target      = (bus.angle_in > ANGLE_MAX) ? ANGLE_MAX : bus.angle_in;

`ifdef SERVO_SLEW_EN
    localparam logic [7:0] STEP = (SLEW_STEP > 255) ? 8'd255 : 8'(SLEW_STEP);

    logic [7:0] dist;

    always_comb begin
        dist = (target > angle_cur_q) ? (target - angle_cur_q) : (angle_cur_q - target);
        if (dist > STEP) begin
            dist = STEP;
        end
        angle_new = (target > angle_cur_q) ? (angle_cur_q + dist) : (angle_cur_q - dist);
        busy_new  = (angle_new != target);
    end
`else
    assign angle_new = target;
    assign busy_new  = 1'b0;
`endif

    assign pulse_w_new = PW_W'(MIN_PULSE) + PW_W'(angle_new) * PW_W'(TICKS_PER_DEG);

    // cnt as sampled at an edge is the frame position of the cycle being
    // entered, so pwm_q for position c is simply (c < pulse_w). Position 0
    // always carries the pulse because MIN_PULSE >= 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pulse_w     <= PW_IDLE;
            angle_cur_q <= ANGLE_IDLE;
            busy_q      <= 1'b0;
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else if (!bus.enable) begin
            cnt         <= '0;
            angle_cur_q <= ANGLE_IDLE;
            busy_q      <= 1'b0;
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            tick_q <= frame_start;
            if (frame_start) begin
                angle_cur_q <= angle_new;
                busy_q      <= busy_new;
                pulse_w     <= pulse_w_new;
                pwm_q       <= 1'b1;
            end else begin
                pwm_q <= (32'(cnt) < 32'(pulse_w));
            end
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.frame_tick = tick_q;
    assign bus.angle_cur  = angle_cur_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver
//   Self-checking bench for servo_pwm_driver with a shortened frame
//   (FRAME_TICKS=400, MIN_PULSE=10, TICKS_PER_DEG=2, so 0..180 deg maps to a
//   10..370 cycle pulse). A frame-level reference model predicts every output
//   each cycle; table vectors and directed sequences cover the corner cases.
module tb_servo_pwm_driver;
    localparam int FRAME = 400;
    localparam int MINP  = 10;
    localparam int TPD   = 2;
    localparam int SLEW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_pwm_driver_if bus ();

    servo_pwm_driver #(
        .CLK_FREQ     (1_000_000),
        .FRAME_TICKS  (FRAME),
        .MIN_PULSE    (MINP),
        .TICKS_PER_DEG(TPD),
        .SLEW_STEP    (SLEW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    bit sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position in the frame (-1 = idle) and derives
    // the applied angle and pulse width from the frame-start rules.
    int         m_pos  = -1;
    int         m_ang  = 90;
    int         m_pw   = MINP + 90 * TPD;
    bit         m_busy = 1'b0;
    bit         m_pwm  = 1'b0;
    bit         m_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int t;
        int d;
        if (!rst_n) begin
            m_pos = -1; m_ang = 90; m_pw = MINP + 90 * TPD;
            m_busy = 1'b0; m_pwm = 1'b0; m_tick = 1'b0;
        end else if (!bus.enable) begin
            m_pos = -1; m_ang = 90; m_busy = 1'b0; m_pwm = 1'b0; m_tick = 1'b0;
        end else begin
            if (m_pos < 0 || m_pos == FRAME - 1) begin
                m_pos = 0;
                t = (int'(bus.angle_in) > 180) ? 180 : int'(bus.angle_in);
`ifdef SERVO_SLEW_EN
                d = t - m_ang;
                if (d > SLEW) d = SLEW;
                if (d < -SLEW) d = -SLEW;
                m_ang = m_ang + d;
                m_busy = (m_ang != t);
`else
                d = 0;
                m_ang = t + d;
                m_busy = 1'b0;
`endif
                m_pw = MINP + m_ang * TPD;
                m_tick = 1'b1;
            end else begin
                m_pos++;
                m_tick = 1'b0;
            end
            m_pwm = (m_pos < m_pw);
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            check("scoreboard {pwm,tick,busy,angle}",
                  {21'd0, bus.pwm_out, bus.frame_tick, bus.busy, bus.angle_cur},
                  {21'd0, m_pwm, m_tick, m_busy, 8'(m_ang)});
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            @(negedge clk);
            if (bus.frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered at the negedge of a frame_tick cycle; leaves at the next one.
    task automatic measure_frame(input int chg_at, input logic [7:0] chg_val,
                                 output int width, output int period, output int ang);
        width = 0;
        period = 0;
        ang = int'(bus.angle_cur);
        do begin
            if (bus.pwm_out) width++;
            period++;
            if (period == chg_at) bus.angle_in = chg_val;
            @(negedge clk);
        end while (!bus.frame_tick && period < 2 * FRAME);
    endtask

    typedef struct {
        logic [7:0] angle;
        int         exp_ang;
        int         exp_width;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int w, p, a, n, ticks;

        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int w, p, a, n, ticks;
        bit busy_prev;

        vecs[0] = '{8'd0,   0,   10};
        vecs[1] = '{8'd1,   1,   12};
        vecs[2] = '{8'd90,  90,  190};
        vecs[3] = '{8'd179, 179, 368};
        vecs[4] = '{8'd180, 180, 370};
        vecs[5] = '{8'd181, 180, 370};
        vecs[6] = '{8'd200, 180, 370};
        vecs[7] = '{8'd255, 180, 370};

        bus.enable = 1'b0;
        bus.angle_in = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sb_en = 1'b1;
        check("reset pwm_out", 32'(bus.pwm_out), 0);
        check("reset frame_tick", 32'(bus.frame_tick), 0);
        check("reset angle_cur", 32'(bus.angle_cur), 90);
        check("reset busy", 32'(bus.busy), 0);

        rst_n = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        check("first frame tick", 32'(bus.frame_tick), 1);
        check("first frame pwm", 32'(bus.pwm_out), 1);
        measure_frame(-1, 8'd0, w, p, a);
        check("angle0 width", 32'(w), 10);
        check("angle0 period", 32'(p), FRAME);

`ifndef SERVO_SLEW_EN
        foreach (vecs[i]) begin
            bus.angle_in = vecs[i].angle;
            wait_tick(ok);
            check("vec wait_tick", 32'(ok), 1);
            measure_frame(-1, 8'd0, w, p, a);
            check($sformatf("vec%0d width", i), 32'(w), 32'(vecs[i].exp_width));
            check($sformatf("vec%0d period", i), 32'(p), FRAME);
            check($sformatf("vec%0d angle_cur", i), 32'(a), 32'(vecs[i].exp_ang));
        end

        // Mid-frame request change only lands at the following frame start.
        bus.angle_in = 8'd45;
        wait_tick(ok);
        check("midchg wait_tick", 32'(ok), 1);
        measure_frame(FRAME / 2, 8'd135, w, p, a);
        check("midchg current width", 32'(w), 100);
        check("midchg current angle", 32'(a), 45);
        measure_frame(-1, 8'd0, w, p, a);
        check("midchg next width", 32'(w), 280);
        check("midchg next angle", 32'(a), 135);
`else
        // Slew from a steady 90 toward 180 in 4-degree steps.
        bus.angle_in = 8'd90;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        check("slew start angle", 32'(bus.angle_cur), 90);
        bus.angle_in = 8'd180;
        n = 0;
        busy_prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            wait_tick(ok);
            n++;
            if (n == 1) check("slew first step", 32'(bus.angle_cur), 94);
            if (bus.angle_cur == 8'd180 || !ok) break;
            busy_prev = bus.busy;
        end
        check("slew frames to target", 32'(n), 23);
        check("slew busy before target", 32'(busy_prev), 1);
        check("slew busy at target", 32'(bus.busy), 0);
`endif

        // Enable dropped mid-pulse: output quiet next cycle, restart at once.
        bus.angle_in = 8'd90;
        wait_tick(ok);
        wait_tick(ok);
        check("endrop wait_tick", 32'(ok), 1);
        repeat (10) @(negedge clk);
        check("endrop pwm before", 32'(bus.pwm_out), 1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("endrop pwm", 32'(bus.pwm_out), 0);
        check("endrop angle_cur", 32'(bus.angle_cur), 90);
        check("endrop busy", 32'(bus.busy), 0);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.frame_tick || bus.pwm_out) ticks++;
        end
        check("endrop quiet", 32'(ticks), 0);
        bus.enable = 1'b1;
        @(negedge clk);
        check("endrop restart tick", 32'(bus.frame_tick), 1);
        check("endrop restart pwm", 32'(bus.pwm_out), 1);

        // Asynchronous reset in the middle of a pulse.
        bus.angle_in = 8'd180;
        wait_tick(ok);
        repeat (20) @(negedge clk);
        check("arst pwm before", 32'(bus.pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst pwm async", 32'(bus.pwm_out), 0);
        check("arst angle_cur", 32'(bus.angle_cur), 90);
        check("arst busy", 32'(bus.busy), 0);
        check("arst frame_tick", 32'(bus.frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst restart tick", 32'(bus.frame_tick), 1);
        measure_frame(-1, 8'd0, w, p, a);
        check("arst restart period", 32'(p), FRAME);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            bus.angle_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clk);
                bus.enable = 1'b1;
            end
            repeat ($urandom_range(1, 300)) @(negedge clk);
        end

        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
